// File: rtl/snn_pkg.sv
// snn_pkg: widths and event type shared by the router, spike arbiter and neuron core.
package snn_pkg;
    localparam int DEF_ID_WIDTH     = 16;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int CNT_W            = 16;
    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]     id;
        logic [DEF_WEIGHT_WIDTH-1:0] weight;
    } spike_evt_t;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/spike_in_arbiter_if.sv
// spike_in_arbiter_if: source-side valid/ready channels plus the neuron-side spike_in handshake.
interface spike_in_arbiter_if
    import snn_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int ID_WIDTH     = DEF_ID_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
);
    localparam int SRC_W = $clog2(NUM_SRC);
    logic [NUM_SRC-1:0]              src_valid;
    logic [NUM_SRC-1:0]              src_ready;
    logic [NUM_SRC*ID_WIDTH-1:0]     src_id;
    logic [NUM_SRC*WEIGHT_WIDTH-1:0] src_weight;
    logic                            out_valid;
    logic                            out_ready;
    logic [ID_WIDTH-1:0]             out_id;
    logic [WEIGHT_WIDTH-1:0]         out_weight;
    logic [SRC_W-1:0]                out_src;
    modport slave (
        input  src_valid, src_id, src_weight, out_ready,
        output src_ready, out_valid, out_id, out_weight, out_src
    );
    modport master (
        output src_valid, src_id, src_weight, out_ready,
        input  src_ready, out_valid, out_id, out_weight, out_src
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin select; first request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any
);
    logic [SRC_W:0] idx;
    // scan from the farthest offset down so the nearest request wins
    always_comb begin
        gnt_idx = '0;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (SRC_W+1)'(i);
            idx = idx >= (SRC_W+1)'(NUM_SRC) ? idx - (SRC_W+1)'(NUM_SRC) : idx;
            gnt_idx = req[idx[SRC_W-1:0]] ? idx[SRC_W-1:0] : gnt_idx;
        end
    end
    assign any = |req;
    assign gnt = any ? NUM_SRC'(1) << gnt_idx : '0;
endmodule

// File: rtl/spike_in_arbiter.sv
// spike_in_arbiter: round-robin share of a LIF core's spike input among NUM_SRC sources,
// with a one-entry registered output stage and a saturating delivered-event counter.
module spike_in_arbiter
    import snn_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int ID_WIDTH     = DEF_ID_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int SRC_W        = $clog2(NUM_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] fwd_count,
    spike_in_arbiter_if.slave bus
);
    logic [NUM_SRC-1:0]      gnt;
    logic [SRC_W-1:0]        gnt_idx, rr_ptr, out_src;
    logic                    any, free, grant, out_valid;
    logic [ID_WIDTH-1:0]     out_id;
    logic [WEIGHT_WIDTH-1:0] out_weight;
    rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_rr (
        .req     (bus.src_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );
    assign free  = !out_valid || bus.out_ready;
    // rst_n term keeps src_ready low during reset even though the slot looks free
    assign grant = rst_n && enable && free && any;
    assign bus.src_ready  = grant ? gnt : '0;
    assign bus.out_valid  = out_valid;
    assign bus.out_id     = out_id;
    assign bus.out_weight = out_weight;
    assign bus.out_src    = out_src;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_weight <= '0;
            out_src    <= '0;
            rr_ptr     <= '0;
        end else if (grant) begin
            out_valid  <= 1'b1;
            out_id     <= bus.src_id[gnt_idx*ID_WIDTH +: ID_WIDTH];
            out_weight <= bus.src_weight[gnt_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            out_src    <= gnt_idx;
            rr_ptr     <= gnt_idx == SRC_W'(NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
        end else if (bus.out_ready) begin
            out_valid  <= 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fwd_count <= '0;
        else fwd_count <= cnt_clear ? '0 : (out_valid && bus.out_ready) ? sat_inc(fwd_count) : fwd_count;
    end
endmodule
